// File: rtl/gaussian_blur_3x3.sv
// Streaming 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1] / 16) over a raster-order 8-bit frame.
// Optional macro GAUSS_ROUND_EN: round interior results half-up instead of truncating.

module gaussian_blur_3x3 #(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_pixel,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_pixel,
  output logic       m_last
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t        r_state;
  logic          r_rstDone;
  logic          r_mValid;
  logic          r_mLast;
  logic [7:0]    r_mPixel;
  logic [CW-1:0] r_inCol;
  logic [RW-1:0] r_inRow;
  logic [CW-1:0] r_outCol;
  logic [RW-1:0] r_outRow;
  logic [7:0]    r_lineA [IMAGE_WIDTH];
  logic [7:0]    r_lineB [IMAGE_WIDTH];
  logic [23:0]   r_winL;
  logic [23:0]   r_winC;

  logic          w_accept;
  logic          w_inLast;
  logic          w_outLast;
  logic          w_border;
  logic          w_done;
  logic          w_load;
  logic [7:0]    w_top;
  logic [7:0]    w_mid;
  logic [7:0]    w_blur;
  logic [7:0]    w_outPix;
  logic [11:0]   w_sum;
  logic [11:0]   w_sumAdj;

  // The single-entry output register can take a new pixel whenever it is empty or draining.
  assign s_ready  = (r_state == FILL) ? r_rstDone :
                    (r_state == RUN)  ? (!r_mValid || m_ready) : 1'b0;
  assign w_accept = s_valid && s_ready;

  assign w_inLast  = (r_inRow == LAST_ROW) && (r_inCol == LAST_COL);
  assign w_outLast = (r_outRow == LAST_ROW) && (r_outCol == LAST_COL);
  assign w_border  = (r_outRow == '0) || (r_outRow == LAST_ROW) ||
                     (r_outCol == '0) || (r_outCol == LAST_COL);

  assign w_top = r_lineB[r_inCol];
  assign w_mid = r_lineA[r_inCol];

  // Window columns are {row r-2, row r-1, row r}; the incoming column completes the 3x3 neighbourhood.
  assign w_sum = 12'(r_winL[23:16])         + (12'(r_winL[15:8]) << 1) + 12'(r_winL[7:0]) +
                 (12'(r_winC[23:16]) << 1)  + (12'(r_winC[15:8]) << 2) + (12'(r_winC[7:0]) << 1) +
                 12'(w_top)                 + (12'(w_mid) << 1)        + 12'(s_pixel);

`ifdef GAUSS_ROUND_EN
  assign w_sumAdj = w_sum + 12'd8;
`else
  assign w_sumAdj = w_sum;
`endif

  assign w_blur   = 8'(w_sumAdj >> 4);
  assign w_outPix = w_border ? 8'h00 : w_blur;

  assign w_done = r_mValid && m_ready && r_mLast;
  assign w_load = ((r_state == RUN) && w_accept) ||
                  ((r_state == FLUSH) && !w_done && (!r_mValid || m_ready));

  // Line buffers and window are data-only storage; borders mask any stale contents.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lineA[r_inCol] <= s_pixel;
      r_lineB[r_inCol] <= w_mid;
      r_winL           <= r_winC;
      r_winC           <= {w_top, w_mid, s_pixel};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FILL;
      r_rstDone <= 1'b0;
      r_mValid  <= 1'b0;
      r_mLast   <= 1'b0;
      r_mPixel  <= 8'h00;
      r_inCol   <= '0;
      r_inRow   <= '0;
      r_outCol  <= '0;
      r_outRow  <= '0;
    end else begin
      r_rstDone <= 1'b1;

      if (w_accept) begin
        if (r_inCol == LAST_COL) begin
          r_inCol <= '0;
          r_inRow <= r_inRow + 1'b1;
        end else begin
          r_inCol <= r_inCol + 1'b1;
        end
      end

      if (w_load) begin
        r_mValid <= 1'b1;
        r_mPixel <= w_outPix;
        r_mLast  <= w_outLast;
        if (r_outCol == LAST_COL) begin
          r_outCol <= '0;
          r_outRow <= r_outRow + 1'b1;
        end else begin
          r_outCol <= r_outCol + 1'b1;
        end
      end else if (r_mValid && m_ready) begin
        r_mValid <= 1'b0;
        r_mLast  <= 1'b0;
      end

      // Pixel index W (row 1, col 0) is the last one needed before the first centre is complete.
      case (r_state)
        FILL: begin
          if (w_accept && (r_inRow == RW'(1)) && (r_inCol == '0)) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_accept && w_inLast) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_done) begin
            r_state  <= FILL;
            r_inCol  <= '0;
            r_inRow  <= '0;
            r_outCol <= '0;
            r_outRow <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign m_valid = r_mValid;
  assign m_pixel = r_mPixel;
  assign m_last  = r_mLast;

endmodule

// File: doc/gaussian_blur_3x3.md
GAUSSIAN_BLUR_3X3 -- requirements
Module: gaussian_blur_3x3

Interface
REQ-001 Parameter IMAGE_WIDTH, default 512, pixels per row (W), minimum 3.
REQ-002 Parameter IMAGE_HEIGHT, default 512, rows per frame (H), minimum 3.
REQ-003 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 s_valid  input  1  input pixel valid.
REQ-007 s_ready  output  1  block accepts input pixel this cycle.
REQ-008 s_pixel  input  8  unsigned greyscale input pixel, raster order.
REQ-009 m_valid  output  1  output pixel valid.
REQ-010 m_ready  input  1  downstream accepts output pixel.
REQ-011 m_pixel  output  8  filtered pixel, raster order.
REQ-012 m_last  output  1  high with the final output pixel of a frame (index W*H-1).

Function
REQ-013 Transfer occurs on a channel only when valid and ready are both high at a clock edge; m_valid/m_pixel/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-014 Input and output frames are exactly W*H pixels each; frame boundaries are tracked by internal row/column counters only.
REQ-015 Two line buffers of W x 8 bits plus a 3x3 shift window SHALL hold rows r-1, r, r+1.
REQ-016 Kernel, fixed: [1 2 1; 2 4 2; 1 2 1]; weighted sum SHALL be computed at 12 bits unsigned (max 4080, no overflow).
REQ-017 Interior output (1<=r<=H-2, 1<=c<=W-1-1) SHALL equal sum>>4, adjusted per REQ-028.
REQ-018 Border outputs (r=0, r=H-1, c=0, c=W-1) SHALL be 8'h00.
REQ-019 FSM states: FILL, RUN, FLUSH.
REQ-020 FILL: s_ready=1, m_valid=0; accepts the first W+1 pixels of a frame, then moves to RUN.
REQ-021 RUN: each accepted input produces exactly one output for pixel index (input index - W - 1); output register is single-entry; s_ready = !m_valid || m_ready, so accept and output handoff may occur in the same cycle.
REQ-022 After the W*H-th input is accepted, RUN SHALL move to FLUSH; s_ready=0 in FLUSH.
REQ-023 FLUSH SHALL emit the remaining W+1 outputs (all border, value 0), one per m_valid&m_ready handshake, asserting m_last on the last one.
REQ-024 When the m_last pixel is transferred, state SHALL return to FILL with all counters zeroed; next frame starts on the following cycle.
REQ-025 Latency in RUN: output for input handshake at edge N SHALL present m_valid at edge N+1 (one register stage).
REQ-026 Line buffer contents SHALL not be reset; uninitialised data never reaches an interior output.

Reset
REQ-027 While rst_n=0: state=FILL, row/column/output counters=0, m_valid=0, m_pixel=8'h00, m_last=0, s_ready=0; s_ready SHALL go to 1 the first cycle after deassertion. Reset mid-frame SHALL discard the partial frame; the next accepted pixel is pixel (0,0).

Configuration
REQ-028 Macro GAUSS_ROUND_EN: when defined, interior output = (sum+8)>>4 (round half up, max 255); when undefined, interior output = sum>>4 (truncate).

Verification
REQ-029 W=4,H=4, all pixels 100, m_ready=1 -> 16 outputs; (1,1),(1,2),(2,1),(2,2)=100, other 12=0; m_last only on 16th.
REQ-030 W=5,H=5, zeros except (2,2)=64 -> (2,2)=16, (1,2),(2,1),(2,3),(3,2)=8, (1,1),(1,3),(3,1),(3,3)=4, rest 0.
REQ-031 W=5,H=5, zeros except (2,2)=2 -> (2,2)=1 with GAUSS_ROUND_EN, 0 without.
REQ-032 W=4,H=4, all 200, m_ready toggles 1/0 every cycle, s_valid random -> exactly 16 outputs, same values as REQ-029 pattern scaled (interior 200), no drop/duplicate, outputs stable while stalled.
REQ-033 Send 7 pixels of a W=4,H=4 frame, pulse rst_n low 1 cycle -> m_valid=0, s_ready=0 during reset; then a full 100-valued frame yields exactly REQ-029 output.
REQ-034 Two back-to-back W=4,H=4 frames (values 100 then 50) -> 32 outputs, m_last on 16th and 32nd, second frame interior=50.
